// File: rtl/vp_block_receiver.sv
// vp_block_receiver
//
// Per-core Wishbone slave behind the memory controller. It packs the 32-bit
// beat stream of a block copy into one 64-bit code-memory word (2 beats) or
// one 96-bit data-memory word (3 beats). It then issues a single-cycle write
// into the core's instruction or data memory.
//
// The first beat of a block sets the block type (TAG_I) and the word address
// (ADR_I). The first beat lands in the most significant lane, and later beats
// fill the lower lanes in order. Each accepted beat is acknowledged for exactly
// one cycle. Because a new beat is only taken while ACK_O is low, a strobe
// that stays high across the acknowledge is counted once.
//
// Optional build macro:
//   VPRX_BOUNDS_CHECK_EN - when defined, a block whose latched address is at or
//                          beyond CODE_DEPTH / DATA_DEPTH is still fully
//                          acknowledged, but its write is suppressed and
//                          oError is set. When undefined, addresses simply
//                          wrap to the memory address width.
//
// Ports:
//   Clock, Reset        system clock, synchronous active-high reset
//   DAT_I, ADR_I        beat data and destination word address (low bits used)
//   STB_I, WE_I         beat strobe, this-core select
//   TAG_I               block type (instruction / data; other values ignored)
//   CYC_I, MST_I        bus cycle active, master owns the bus
//   ACK_O               beat acknowledge (one cycle after acceptance)
//   oCodeWrite*         code-memory write strobe / address / 64-bit data
//   oDataWrite*         data-memory write strobe / address / 96-bit data
//   oBusy               a block is being assembled or committed
//   oError              sticky: abort (or out-of-range block); cleared by Reset
module vp_block_receiver #(
  parameter int CODE_ADDR_W = 16,
  parameter int DATA_ADDR_W = 14,
  parameter int CODE_DEPTH  = 65536,
  parameter int DATA_DEPTH  = 16384,
  localparam int WB_WIDTH = 32,
  localparam logic [1:0] TAG_INSTRUCTION_ADDRESS_TYPE = 2'd1,
  localparam logic [1:0] TAG_DATA_ADDRESS_TYPE        = 2'd2
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [WB_WIDTH-1:0]    DAT_I,
  input  logic [WB_WIDTH-1:0]    ADR_I,
  input  logic                   STB_I,
  input  logic                   WE_I,
  input  logic [1:0]             TAG_I,
  input  logic                   CYC_I,
  input  logic                   MST_I,
  output logic                   ACK_O,
  output logic                   oCodeWriteEnable,
  output logic [CODE_ADDR_W-1:0] oCodeWriteAddress,
  output logic [63:0]            oCodeWriteData,
  output logic                   oDataWriteEnable,
  output logic [DATA_ADDR_W-1:0] oDataWriteAddress,
  output logic [95:0]            oDataWriteData,
  output logic                   oBusy,
  output logic                   oError
);

  localparam int ADDR_KEEP = (CODE_ADDR_W > DATA_ADDR_W) ? CODE_ADDR_W : DATA_ADDR_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMMIT  = 2'd2
  } stateT;

  stateT                  state;
  stateT                  nextState;
  logic                   blkIsCode;
  logic [ADDR_KEEP-1:0]   blkAddr;
  logic [1:0]             beatCnt;
  logic [63:0]            beatBuf;
  logic                   tagValid;
  logic                   accept;
  logic                   finalBeat;
  logic                   commitOk;
  logic [CODE_ADDR_W-1:0] codeAddr;
  logic [DATA_ADDR_W-1:0] dataAddr;
  logic                   unusedAdrHi;

  // Address bits above both memory widths are never needed.
  assign unusedAdrHi = ^ADR_I[WB_WIDTH-1:ADDR_KEEP];

  assign tagValid = (TAG_I == TAG_INSTRUCTION_ADDRESS_TYPE) ||
                    (TAG_I == TAG_DATA_ADDRESS_TYPE);

  // ~ACK_O forces a one-cycle gap after every acknowledged beat, so a strobe
  // held high across the acknowledge is not taken twice.
  assign accept = CYC_I & MST_I & STB_I & WE_I & ~ACK_O & tagValid;

  // The last beat arrives with the count one short of the target
  // (2 beats for code, 3 beats for data).
  assign finalBeat = accept && (state == COLLECT) &&
                     (beatCnt == (blkIsCode ? 2'd1 : 2'd2));

  assign codeAddr = blkAddr[CODE_ADDR_W-1:0];
  assign dataAddr = blkAddr[DATA_ADDR_W-1:0];

`ifdef VPRX_BOUNDS_CHECK_EN
  logic codeInRange;
  logic dataInRange;

  assign codeInRange = (64'(codeAddr) < 64'(CODE_DEPTH));
  assign dataInRange = (64'(dataAddr) < 64'(DATA_DEPTH));
  assign commitOk    = blkIsCode ? codeInRange : dataInRange;
`else
  logic unusedDepths;

  // The depths only matter when bounds checking is built in.
  assign unusedDepths = ^{CODE_DEPTH, DATA_DEPTH};
  assign commitOk     = 1'b1;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState        = state;
    oBusy            = (state != IDLE);
    oCodeWriteEnable = 1'b0;
    oDataWriteEnable = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          nextState = COLLECT;
        end
      end
      COLLECT: begin
        // Losing the bus cycle mid-block drops the partial word.
        if (!CYC_I) begin
          nextState = IDLE;
        end else if (finalBeat) begin
          nextState = COMMIT;
        end
      end
      COMMIT: begin
        nextState        = IDLE;
        oCodeWriteEnable = blkIsCode & commitOk;
        oDataWriteEnable = ~blkIsCode & commitOk;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Block context, acknowledge, error flag and the registered write ports.
  // The write address and data load on the final beat, so they are valid in
  // the commit cycle. They then hold until the next committed block.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ACK_O             <= 1'b0;
      blkIsCode         <= 1'b0;
      blkAddr           <= '0;
      beatCnt           <= 2'd0;
      oError            <= 1'b0;
      oCodeWriteAddress <= '0;
      oCodeWriteData    <= '0;
      oDataWriteAddress <= '0;
      oDataWriteData    <= '0;
    end else begin
      ACK_O <= accept;

      if ((state == IDLE) && accept) begin
        blkIsCode <= (TAG_I == TAG_INSTRUCTION_ADDRESS_TYPE);
        blkAddr   <= ADR_I[ADDR_KEEP-1:0];
        beatCnt   <= 2'd1;
      end else if ((state == COLLECT) && accept) begin
        beatCnt <= beatCnt + 2'd1;
      end

      if ((state == COLLECT) && !CYC_I) begin
        oError <= 1'b1;
      end else if ((state == COMMIT) && !commitOk) begin
        oError <= 1'b1;
      end

      if (finalBeat && commitOk) begin
        if (blkIsCode) begin
          oCodeWriteAddress <= codeAddr;
          oCodeWriteData    <= {beatBuf[31:0], DAT_I};
        end else begin
          oDataWriteAddress <= dataAddr;
          oDataWriteData    <= {beatBuf, DAT_I};
        end
      end
    end
  end

  // Beat shift buffer: earlier beats move toward the top lane as later beats
  // arrive. The final beat is merged directly into the write data above.
  always_ff @(posedge Clock) begin
    if (accept) begin
      beatBuf <= {beatBuf[31:0], DAT_I};
    end
  end

endmodule

// File: tb/tb_vp_block_receiver.sv
// Testbench for vp_block_receiver: table-driven block vectors plus
// hand-written sequences for back-to-back, abort and mid-block reset.
module tb_vp_block_receiver;

  localparam logic [1:0] TAG_CODE = 2'd1;
  localparam logic [1:0] TAG_DATA = 2'd2;
  localparam logic [1:0] TAG_BAD  = 2'd3;

`ifdef VPRX_BOUNDS_CHECK_EN
  localparam int TB_DATA_DEPTH = 16;
  localparam bit BOUNDS = 1'b1;
`else
  localparam int TB_DATA_DEPTH = 16384;
  localparam bit BOUNDS = 1'b0;
`endif

  logic        Clock;
  logic        Reset;
  logic [31:0] DAT_I;
  logic [31:0] ADR_I;
  logic        STB_I;
  logic        WE_I;
  logic [1:0]  TAG_I;
  logic        CYC_I;
  logic        MST_I;
  logic        ACK_O;
  logic        oCodeWriteEnable;
  logic [15:0] oCodeWriteAddress;
  logic [63:0] oCodeWriteData;
  logic        oDataWriteEnable;
  logic [13:0] oDataWriteAddress;
  logic [95:0] oDataWriteData;
  logic        oBusy;
  logic        oError;

  vp_block_receiver #(
    .CODE_ADDR_W(16),
    .DATA_ADDR_W(14),
    .CODE_DEPTH (65536),
    .DATA_DEPTH (TB_DATA_DEPTH)
  ) dut (
    .Clock            (Clock),
    .Reset            (Reset),
    .DAT_I            (DAT_I),
    .ADR_I            (ADR_I),
    .STB_I            (STB_I),
    .WE_I             (WE_I),
    .TAG_I            (TAG_I),
    .CYC_I            (CYC_I),
    .MST_I            (MST_I),
    .ACK_O            (ACK_O),
    .oCodeWriteEnable (oCodeWriteEnable),
    .oCodeWriteAddress(oCodeWriteAddress),
    .oCodeWriteData   (oCodeWriteData),
    .oDataWriteEnable (oDataWriteEnable),
    .oDataWriteAddress(oDataWriteAddress),
    .oDataWriteData   (oDataWriteData),
    .oBusy            (oBusy),
    .oError           (oError)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int nChecks = 0;
  int nErr    = 0;

  // Event monitor, sampled on the falling edge.
  int          ackCnt  = 0;
  int          codeCnt = 0;
  int          dataCnt = 0;
  logic [15:0] lastCodeAddr = '0;
  logic [63:0] lastCodeData = '0;
  logic [13:0] lastDataAddr = '0;
  logic [95:0] lastDataData = '0;
  logic [15:0] codeAddrQ[$];
  logic [63:0] codeDataQ[$];
  bit          bothHigh = 1'b0;
  bit          enNoAck  = 1'b0;
  bit          busyAfterCommit = 1'b0;
  bit          prevEn = 1'b0;

  always @(negedge Clock) begin
    if (ACK_O) ackCnt++;
    if (oCodeWriteEnable) begin
      codeCnt++;
      lastCodeAddr = oCodeWriteAddress;
      lastCodeData = oCodeWriteData;
      codeAddrQ.push_back(oCodeWriteAddress);
      codeDataQ.push_back(oCodeWriteData);
    end
    if (oDataWriteEnable) begin
      dataCnt++;
      lastDataAddr = oDataWriteAddress;
      lastDataData = oDataWriteData;
    end
    if (oCodeWriteEnable && oDataWriteEnable) bothHigh = 1'b1;
    if ((oCodeWriteEnable || oDataWriteEnable) && !ACK_O) enNoAck = 1'b1;
    if (prevEn && oBusy) busyAfterCommit = 1'b1;
    prevEn = oCodeWriteEnable || oDataWriteEnable;
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one beat at a falling edge and hold it through the accept edge
  // and the acknowledge edge, leaving STB_I high.
  task automatic beat(input logic [1:0] tag, input logic [31:0] adr,
                      input logic [31:0] dat, input logic we);
    CYC_I = 1'b1;
    MST_I = 1'b1;
    STB_I = 1'b1;
    WE_I  = we;
    TAG_I = tag;
    ADR_I = adr;
    DAT_I = dat;
    @(negedge Clock);
    @(negedge Clock);
  endtask

  task automatic idle(input int n);
    STB_I = 1'b0;
    CYC_I = 1'b0;
    WE_I  = 1'b0;
    repeat (n) @(negedge Clock);
  endtask

  function automatic bit dataOk(input logic [31:0] adr);
    return ({18'b0, adr[13:0]} < 32'(TB_DATA_DEPTH)) || !BOUNDS;
  endfunction

  typedef struct {
    string            name;
    logic [1:0]       tag;
    logic [1:0]       tagRest;
    logic [31:0]      adr;
    logic [31:0]      adrRest;
    logic             we;
    int               nBeats;
    logic [2:0][31:0] beats;
    int               expAcks;
    int               expCode;
    int               expData;
    logic [31:0]      expAddr;
    logic [95:0]      expWord;
  } vecT;

  function automatic vecT mk(input string name, input logic [1:0] tag, input logic [1:0] tagRest,
                             input logic [31:0] adr, input logic [31:0] adrRest, input logic we,
                             input int nBeats, input logic [31:0] b0, input logic [31:0] b1,
                             input logic [31:0] b2, input int expAcks, input int expCode,
                             input int expData, input logic [31:0] expAddr,
                             input logic [95:0] expWord);
    vecT v;
    v.name = name; v.tag = tag; v.tagRest = tagRest; v.adr = adr; v.adrRest = adrRest;
    v.we = we; v.nBeats = nBeats;
    v.beats[0] = b0; v.beats[1] = b1; v.beats[2] = b2;
    v.expAcks = expAcks; v.expCode = expCode; v.expData = expData;
    v.expAddr = expAddr; v.expWord = expWord;
    return v;
  endfunction

  vecT vecs[6];

  initial begin
    int  a0, c0, d0, expD;
    bit  expErr;
    expErr = 1'b0;

    vecs[0] = mk("code", TAG_CODE, TAG_CODE, 32'h10, 32'h10, 1'b1, 2,
                 32'hAAAA0001, 32'hBBBB0002, 32'h0, 2, 1, 0, 32'h10,
                 96'h00000000_AAAA0001_BBBB0002);
    vecs[1] = mk("data", TAG_DATA, TAG_DATA, 32'h20, 32'h20, 1'b1, 3,
                 32'h1, 32'h2, 32'h3, 3, 0, 1, 32'h20,
                 96'h00000001_00000002_00000003);
    vecs[2] = mk("deselect", TAG_CODE, TAG_CODE, 32'h30, 32'h30, 1'b0, 2,
                 32'h5, 32'h6, 32'h0, 0, 0, 0, 32'h0, 96'h0);
    vecs[3] = mk("datawrap", TAG_DATA, TAG_DATA, 32'h4010, 32'h4010, 1'b1, 3,
                 32'h11, 32'h22, 32'h33, 3, 0, 1, 32'h10,
                 96'h00000011_00000022_00000033);
    vecs[4] = mk("badtag", TAG_BAD, TAG_BAD, 32'h40, 32'h40, 1'b1, 2,
                 32'h7, 32'h8, 32'h0, 0, 0, 0, 32'h0, 96'h0);
    vecs[5] = mk("latched", TAG_CODE, TAG_DATA, 32'h70, 32'h99, 1'b1, 2,
                 32'h12345678, 32'h9ABCDEF0, 32'h0, 2, 1, 0, 32'h70,
                 96'h00000000_12345678_9ABCDEF0);

    Reset = 1'b1;
    DAT_I = '0; ADR_I = '0; STB_I = 1'b0; WE_I = 1'b0;
    TAG_I = '0; CYC_I = 1'b0; MST_I = 1'b0;
    repeat (3) @(negedge Clock);

    check("rst_ack",   96'(ACK_O), 96'(0));
    check("rst_busy",  96'(oBusy), 96'(0));
    check("rst_err",   96'(oError), 96'(0));
    check("rst_en",    96'({oCodeWriteEnable, oDataWriteEnable}), 96'(0));
    check("rst_cdata", 96'(oCodeWriteData), 96'(0));
    check("rst_ddata", oDataWriteData, 96'(0));
    Reset = 1'b0;
    @(negedge Clock);

    for (int i = 0; i < 6; i++) begin
      a0 = ackCnt; c0 = codeCnt; d0 = dataCnt;
      for (int b = 0; b < vecs[i].nBeats; b++) begin
        beat((b == 0) ? vecs[i].tag : vecs[i].tagRest,
             (b == 0) ? vecs[i].adr : vecs[i].adrRest,
             vecs[i].beats[b], vecs[i].we);
      end
      idle(2);
      expD = vecs[i].expData;
      if (vecs[i].tag == TAG_DATA && expD != 0 && !dataOk(vecs[i].adr)) begin
        expD   = 0;
        expErr = 1'b1;
      end
      check({vecs[i].name, "_acks"}, 96'(ackCnt - a0), 96'(vecs[i].expAcks));
      check({vecs[i].name, "_codewr"}, 96'(codeCnt - c0), 96'(vecs[i].expCode));
      check({vecs[i].name, "_datawr"}, 96'(dataCnt - d0), 96'(expD));
      if (vecs[i].expCode != 0) begin
        check({vecs[i].name, "_caddr"}, 96'(lastCodeAddr), 96'(vecs[i].expAddr[15:0]));
        check({vecs[i].name, "_cdata"}, 96'(lastCodeData), vecs[i].expWord);
      end
      if (expD != 0) begin
        check({vecs[i].name, "_daddr"}, 96'(lastDataAddr), 96'(vecs[i].expAddr[13:0]));
        check({vecs[i].name, "_ddata"}, lastDataData, vecs[i].expWord);
      end
      check({vecs[i].name, "_busy"}, 96'(oBusy), 96'(0));
      check({vecs[i].name, "_err"}, 96'(oError), 96'(expErr));
    end

    // Back-to-back code blocks at full rate with STB_I held high throughout.
    codeAddrQ.delete();
    codeDataQ.delete();
    a0 = ackCnt;
    for (int k = 0; k < 4; k++) begin
      beat(TAG_CODE, 32'(k), 32'h1000_0000 | 32'(k), 1'b1);
      beat(TAG_CODE, 32'(k), 32'h2000_0000 | 32'(k), 1'b1);
    end
    idle(2);
    check("b2b_acks", 96'(ackCnt - a0), 96'(8));
    check("b2b_writes", 96'(codeAddrQ.size()), 96'(4));
    for (int k = 0; k < 4 && k < codeAddrQ.size(); k++) begin
      check("b2b_addr", 96'(codeAddrQ[k]), 96'(k));
      check("b2b_data", 96'(codeDataQ[k]),
            96'({32'h1000_0000 | 32'(k), 32'h2000_0000 | 32'(k)}));
    end

    // Abort: CYC_I drops after 2 of 3 data beats.
    d0 = dataCnt;
    beat(TAG_DATA, 32'h50, 32'hD1, 1'b1);
    beat(TAG_DATA, 32'h50, 32'hD2, 1'b1);
    check("abort_busy_before", 96'(oBusy), 96'(1));
    CYC_I = 1'b0;
    STB_I = 1'b0;
    @(negedge Clock);
    expErr = 1'b1;
    check("abort_busy", 96'(oBusy), 96'(0));
    check("abort_err", 96'(oError), 96'(1));
    idle(2);
    check("abort_nowrite", 96'(dataCnt - d0), 96'(0));
    d0 = dataCnt;
    beat(TAG_DATA, 32'h5, 32'hA, 1'b1);
    beat(TAG_DATA, 32'h5, 32'hB, 1'b1);
    beat(TAG_DATA, 32'h5, 32'hC, 1'b1);
    idle(2);
    check("after_abort_wr", 96'(dataCnt - d0), 96'(1));
    check("after_abort_addr", 96'(lastDataAddr), 96'(14'h5));
    check("after_abort_data", lastDataData, 96'h0000000A_0000000B_0000000C);
    check("after_abort_err", 96'(oError), 96'(1));

    // Reset after the first beat of a code block.
    beat(TAG_CODE, 32'h60, 32'hEEEE0001, 1'b1);
    check("mid_busy", 96'(oBusy), 96'(1));
    Reset = 1'b1;
    STB_I = 1'b0;
    CYC_I = 1'b0;
    @(negedge Clock);
    expErr = 1'b0;
    check("midrst_busy",  96'(oBusy), 96'(0));
    check("midrst_err",   96'(oError), 96'(0));
    check("midrst_caddr", 96'(oCodeWriteAddress), 96'(0));
    check("midrst_cdata", 96'(oCodeWriteData), 96'(0));
    check("midrst_daddr", 96'(oDataWriteAddress), 96'(0));
    check("midrst_ddata", oDataWriteData, 96'(0));
    Reset = 1'b0;
    @(negedge Clock);
    c0 = codeCnt;
    beat(TAG_CODE, 32'h61, 32'hCAFE0001, 1'b1);
    beat(TAG_CODE, 32'h61, 32'hCAFE0002, 1'b1);
    idle(2);
    check("after_rst_wr", 96'(codeCnt - c0), 96'(1));
    check("after_rst_addr", 96'(lastCodeAddr), 96'(16'h61));
    check("after_rst_data", 96'(lastCodeData), 96'(64'hCAFE0001_CAFE0002));
    check("after_rst_err", 96'(oError), 96'(expErr));

    check("en_exclusive", 96'(bothHigh), 96'(0));
    check("en_with_ack", 96'(enNoAck), 96'(0));
    check("idle_after_commit", 96'(busyAfterCommit), 96'(0));

    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

endmodule
